// File: rtl/accum_drain_pool_engine.sv
// Accumulator drain engine: rounded requantisation, ReLU/saturation, optional 2x2 pooling.
// Optional macro ACCUM_DRAIN_POOL_AVG_POOL_EN adds pool_mode (1 = 2x2 average pooling).
module accum_drain_pool_engine #(
    parameter int LANES     = 16,
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 8,
    parameter int MAX_WIDTH = 128,
    parameter int DIM_W     = 8,
    parameter int ADDR_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIM_W-1:0]         img_width,
    input  logic [DIM_W-1:0]         img_height,
    input  logic                     pool_en,
    input  logic [4:0]               shift,
`ifdef ACCUM_DRAIN_POOL_AVG_POOL_EN
    input  logic                     pool_mode,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACC_W-1:0]   in_data,
    output logic                     out_valid,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int HALF  = MAX_WIDTH / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic signed [ACC_W:0] PIX_MAX = $signed((ACC_W+1)'((2**OUT_W) - 1));

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH, ST_DONE} state_t;

    state_t             state_q;
    logic [DIM_W-1:0]   width_q, height_q, x_q, y_q;
    logic               poolEn_q, poolMode_q, flush_q;
    logic [4:0]         shift_q;
    logic               inReady_q, busy_q, done_q;

    logic               s1Valid_q;
    logic [LANES*OUT_W-1:0] s1Data_q, s1Pix;
    logic [DIM_W-1:0]   s1X_q, s1Y_q;

    logic [LANES*OUT_W-1:0]     pair_q, pooled, outData_q;
    logic [LANES*(OUT_W+1)-1:0] rowbuf [HALF];
    logic [LANES*(OUT_W+1)-1:0] rowRd, rowWr;
    logic [IDX_W-1:0]           rbIdx;
    logic [ADDR_W-1:0]          outCnt_q, outAddr_q;
    logic                       outValid_q, beat, inPool;

    // Round-half-up shift at ACC_W+1 bits, then clamp into the unsigned pixel range.
    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                                 input logic [4:0] sh);
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        rnd = (sh == 5'd0) ? '0 : $signed((ACC_W+1)'(1) << (sh - 5'd1));
        sum = $signed({acc[ACC_W-1], acc}) + rnd;
        sum = sum >>> sh;
        if (sum < 0)
            return '0;
        else if (sum > PIX_MAX)
            return '1;
        return sum[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W:0] pairWord(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic avg);
        if (avg)
            return {1'b0, a} + {1'b0, b};
        return {1'b0, (a > b) ? a : b};
    endfunction

    function automatic logic [OUT_W-1:0] quadWord(input logic [OUT_W:0] rb,
                                                  input logic [OUT_W:0] pw,
                                                  input logic avg);
        logic [OUT_W+1:0] s;
        s = {1'b0, rb} + {1'b0, pw};
        if (avg)
            return s[OUT_W+1:2];
        return (rb[OUT_W-1:0] > pw[OUT_W-1:0]) ? rb[OUT_W-1:0] : pw[OUT_W-1:0];
    endfunction

    assign beat      = in_valid && inReady_q;
    assign in_ready  = inReady_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_addr  = outAddr_q;

    // Control FSM: latches configuration, walks raster coordinates, then flushes the pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            poolEn_q   <= 1'b0;
            poolMode_q <= 1'b0;
            shift_q    <= '0;
            flush_q    <= 1'b0;
            inReady_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        width_q  <= img_width;
                        height_q <= img_height;
                        poolEn_q <= pool_en;
                        shift_q  <= shift;
`ifdef ACCUM_DRAIN_POOL_AVG_POOL_EN
                        poolMode_q <= pool_mode;
`else
                        poolMode_q <= 1'b0;
`endif
                        x_q       <= '0;
                        y_q       <= '0;
                        inReady_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (beat) begin
                        if (x_q == width_q - DIM_W'(1)) begin
                            x_q <= '0;
                            if (y_q == height_q - DIM_W'(1)) begin
                                inReady_q <= 1'b0;
                                flush_q   <= 1'b0;
                                state_q   <= ST_FLUSH;
                            end else begin
                                y_q <= y_q + DIM_W'(1);
                            end
                        end else begin
                            x_q <= x_q + DIM_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_q <= 1'b1;
                    if (flush_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s1Pix = '0;
        for (int l = 0; l < LANES; l++)
            s1Pix[l*OUT_W +: OUT_W] = requant(in_data[l*ACC_W +: ACC_W], shift_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid_q <= 1'b0;
            s1Data_q  <= '0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
        end else begin
            s1Valid_q <= beat;
            if (beat) begin
                s1Data_q <= s1Pix;
                s1X_q    <= x_q;
                s1Y_q    <= y_q;
            end
        end
    end

    // Pixels past the last even column/row never take part in a pooling window.
    assign inPool = ((s1X_q >> 1) < (width_q >> 1)) && ((s1Y_q >> 1) < (height_q >> 1));
    assign rbIdx  = s1X_q[IDX_W:1];
    assign rowRd  = rowbuf[rbIdx];

    always_comb begin
        rowWr  = '0;
        pooled = '0;
        for (int l = 0; l < LANES; l++) begin
            rowWr[l*(OUT_W+1) +: OUT_W+1] =
                pairWord(pair_q[l*OUT_W +: OUT_W], s1Data_q[l*OUT_W +: OUT_W], poolMode_q);
            pooled[l*OUT_W +: OUT_W] =
                quadWord(rowRd[l*(OUT_W+1) +: OUT_W+1],
                         pairWord(pair_q[l*OUT_W +: OUT_W], s1Data_q[l*OUT_W +: OUT_W], poolMode_q),
                         poolMode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (s1Valid_q && poolEn_q && s1X_q[0] && !s1Y_q[0] && inPool)
            rowbuf[rbIdx] <= rowWr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_q     <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outAddr_q  <= '0;
            outCnt_q   <= '0;
        end else begin
            outValid_q <= 1'b0;
            if (state_q == ST_IDLE && start) begin
                outCnt_q <= '0;
            end else if (s1Valid_q) begin
                if (!poolEn_q) begin
                    outValid_q <= 1'b1;
                    outData_q  <= s1Data_q;
                    outAddr_q  <= outCnt_q;
                    outCnt_q   <= outCnt_q + ADDR_W'(1);
                end else if (!s1X_q[0]) begin
                    pair_q <= s1Data_q;
                end else if (s1Y_q[0] && inPool) begin
                    outValid_q <= 1'b1;
                    outData_q  <= pooled;
                    outAddr_q  <= outCnt_q;
                    outCnt_q   <= outCnt_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/accum_drain_pool_engine.md
Name: accum_drain_pool_engine

Overview:
- Parametrised successor to the fixed 16-lane drain path (accumulator → ReLU → 2x2 max pool → feature BRAM write).
- Accepts one accumulator word per lane per beat in raster order, then applies a rounded requantisation shift and ReLU with saturation.
- Optionally 2x2-pools, and emits pooled pixels with a linear feature-map write address.
- Sits between the accumulator bank and the feature BRAMs. Replaces the free-running drain/pool coordinate counters with a started, counted, handshaked engine.

Parameters:
- LANES, 16, parallel output channels processed per beat
- ACC_W, 24, signed accumulator word width
- OUT_W, 8, unsigned output pixel width
- MAX_WIDTH, 128, largest supported image width (sizes pooling row buffer to MAX_WIDTH/2 entries × LANES)
- DIM_W, 8, width of image dimension inputs
- ADDR_W, 12, output address width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; latches config, begins drain
- img_width  input  DIM_W  pixels per row (2..MAX_WIDTH)
- img_height  input  DIM_W  rows (≥2)
- pool_en  input  1  1 = 2x2 pooling, 0 = pass-through
- shift  input  5  requantisation right shift
- in_valid  input  1  accumulator beat valid
- in_ready  output  1  engine accepts beat
- in_data  input  LANES*ACC_W  signed words, lane i at [i*ACC_W +: ACC_W]
- out_valid  output  1  output pixel valid (BRAM write enable)
- out_data  output  LANES*OUT_W  unsigned pixels, lane-packed as in_data
- out_addr  output  ADDR_W  feature-map write address
- busy  output  1  high from start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0. All counters, the row buffer valid state, and the FSM return to IDLE.
- Reset asserted mid-operation aborts immediately; no further outputs are produced.
- FSM states:
  - IDLE: start latches img_width, img_height, pool_en, shift; x=y=0; goes to DRAIN. Config inputs are ignored after latching.
  - DRAIN: in_ready=1. Each beat (in_valid && in_ready) advances x. x wraps at img_width-1 to 0 with y+1. After beat number img_width*img_height, goes to FLUSH.
  - FLUSH: in_ready=0; holds 2 cycles to drain the pipeline, then goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE. start is ignored while busy.
- in_valid gaps stall the coordinate counters; no bubbles are generated.
- Stage 1 (registered), per lane:
  - r = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift, computed at ACC_W+1 bits.
  - r<0 → 0; r>2^OUT_W-1 → 2^OUT_W-1; otherwise r.
- Stage 2 (registered), pool_en=0:
  - Every beat emits one pixel.
  - out_addr = y*img_width + x (running counter, +1 per output).
  - Latency from beat to out_valid is exactly 2 cycles.
- Stage 2 (registered), pool_en=1:
  - Even x: hold the pixel in a pair register.
  - Odd x, even y: write max(pair, pixel) to rowbuf[x>>1].
  - Odd x, odd y: out_data = max(rowbuf[x>>1], pair, pixel); out_valid=1.
  - out_addr = (y>>1)*(img_width>>1) + (x>>1) (running counter, +1 per output).
  - Latency from the completing beat (odd x, odd y) to out_valid is 2 cycles.
  - Odd img_width: last column discarded. Odd img_height: last row discarded (no output, no rowbuf write).
- out_valid is high for exactly one cycle per emitted pixel. out_addr holds its last value when out_valid=0. After the final output, out_addr is not incremented further.
- Maximum address wrap: out_addr is modulo 2^ADDR_W. The integrator sizes ADDR_W so wrap never occurs.

Optional Feature:
- Macro: ACCUM_DRAIN_POOL_AVG_POOL_EN
- Defined:
  - Adds input port pool_mode (1 bit), latched at start.
  - pool_mode=1 selects 2x2 average instead of max: the rowbuf holds the pair sum at OUT_W+1 bits; output = (sum of 4) >> 2, truncating.
  - pool_mode=0 is identical to the max-pool behaviour above.
- Undefined: port absent; max pooling only.

Test Plan:
- Pass-through, 4x2 image, shift=0, lane0 inputs 0..7, pool_en=0 → 8 outputs, out_addr 0..7, data 0..7; each out_valid exactly 2 cycles after its beat; done pulses 3 cycles after the last beat.
- Rounding/saturation, shift=4, lane0 inputs {24, 23, -100, 10000} → outputs {2, 1, 0, 255}.
- Max pool, 4x4 image, lane0 = raster index 0..15, pool_en=1 → 4 outputs {5, 7, 13, 15} at addrs 0..3.
- Odd dims, 5x3 image, pool_en=1, all 9s → exactly 2 outputs at addrs 0,1; done still asserts after all 15 beats are accepted.
- Backpressure and control: in_valid toggles 1-0-1-0 → output count and addresses unchanged from the gapless run; start during busy is ignored; reset asserted mid-DRAIN → all outputs zero, IDLE, and a fresh start runs correctly.
- With ACCUM_DRAIN_POOL_AVG_POOL_EN, pool_mode=1, 2x2 block {1, 2, 3, 5} → output 2.
